// File: rtl/counter_4bit_ud_if.sv
// Control and status bundle for the up/down counter.
// master: the block that drives the counter. slave: the counter itself.
interface counter_4bit_ud_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_down;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (
    output en, up_down, load, d,
    input  q, tc
  );

  modport slave (
    input  en, up_down, load, d,
    output q, tc
  );
endinterface

// File: rtl/counter_4bit_ud.sv
// Loadable up/down binary counter with terminal-count flag.
// Edge priority: rst, load, en (direction from up_down), hold.
// tc is combinational: it flags that the coming edge will wrap.
module counter_4bit_ud #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  counter_4bit_ud_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;

  logic [WIDTH-1:0] q_r;
  logic             tc_c;

  // Counter register: reset, then load, then count, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= ZERO;
    end else if (bus.load) begin
      q_r <= bus.d;
    end else if (bus.en) begin
      if (bus.up_down) begin
        q_r <= q_r + ONE;
      end else begin
        q_r <= q_r - ONE;
      end
    end
  end

  // Wrap detect: only meaningful when the next edge is a counting edge.
  always_comb begin
    tc_c = 1'b0;
    if (bus.en && !bus.load && !rst) begin
      if (bus.up_down) begin
        tc_c = (q_r == ALL_ONES);
      end else begin
        tc_c = (q_r == ZERO);
      end
    end
  end

  assign bus.q  = q_r;
  assign bus.tc = tc_c;

endmodule

// File: tb/tb_counter_4bit_ud.sv
// Self-checking bench for counter_4bit_ud (WIDTH = 4).
// Each scenario task pushes the expected next q into a scoreboard queue
// before the clock edge, pops it after the edge and compares against q.
// tc is checked against its expected value just before each edge.
module tb_counter_4bit_ud;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [3:0] mq;          // expected current value of q
  logic [3:0] exp_q[$];    // scoreboard of expected next q values

  counter_4bit_ud_if #(.WIDTH(4)) bus ();

  counter_4bit_ud #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [3:0] nq;
    rst = 1'b1; bus.en = 1'b0; bus.up_down = 1'b0; bus.load = 1'b0; bus.d = 4'd0;
    #1;
    checks++;
    if (bus.tc !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc: got %b expected 0", bus.tc);
    end
    exp_q.push_back(4'd0);
    @(posedge clk); #1;
    nq = exp_q.pop_front();
    checks++;
    if (bus.q !== nq) begin
      errors++;
      $display("FAIL reset_q: got %h expected %h", bus.q, nq);
    end
    mq = nq;
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      #1;
      checks++;
      if (bus.tc !== 1'b0) begin
        errors++;
        $display("FAIL hold_tc cycle %0d: got %b expected 0", i, bus.tc);
      end
      exp_q.push_back(4'd0);
      @(posedge clk); #1;
      nq = exp_q.pop_front();
      checks++;
      if (bus.q !== nq) begin
        errors++;
        $display("FAIL hold_q cycle %0d: got %h expected %h", i, bus.q, nq);
      end
      mq = nq;
    end
  endtask

  task automatic test_down();
    logic [3:0] nq;
    logic       etc;
    bus.en = 1'b1; bus.up_down = 1'b0; bus.load = 1'b0; bus.d = 4'd1;
    for (int i = 0; i < 18; i++) begin
      #1;
      etc = (mq == 4'd0);
      checks++;
      if (bus.tc !== etc) begin
        errors++;
        $display("FAIL down_tc cycle %0d: got %b expected %b", i, bus.tc, etc);
      end
      nq = mq - 4'd1;
      exp_q.push_back(nq);
      @(posedge clk); #1;
      nq = exp_q.pop_front();
      checks++;
      if (bus.q !== nq) begin
        errors++;
        $display("FAIL down_q cycle %0d: got %h expected %h", i, bus.q, nq);
      end
      mq = nq;
    end
  endtask

  task automatic test_up();
    logic [3:0] nq;
    logic       etc;
    bus.en = 1'b1; bus.up_down = 1'b1; bus.load = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      etc = (mq == 4'd15);
      checks++;
      if (bus.tc !== etc) begin
        errors++;
        $display("FAIL up_tc cycle %0d: got %b expected %b", i, bus.tc, etc);
      end
      nq = mq + 4'd1;
      exp_q.push_back(nq);
      @(posedge clk); #1;
      nq = exp_q.pop_front();
      checks++;
      if (bus.q !== nq) begin
        errors++;
        $display("FAIL up_q cycle %0d: got %h expected %h", i, bus.q, nq);
      end
      mq = nq;
    end
  endtask

  task automatic test_load();
    logic [3:0] nq;
    logic [3:0] dv;
    dv = 4'd5;
    bus.en = 1'b1; bus.up_down = 1'b1; bus.load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.d = dv;
      #1;
      checks++;
      if (bus.tc !== 1'b0) begin
        errors++;
        $display("FAIL load_tc cycle %0d: got %b expected 0", i, bus.tc);
      end
      exp_q.push_back(dv);
      @(posedge clk); #1;
      nq = exp_q.pop_front();
      checks++;
      if (bus.q !== nq) begin
        errors++;
        $display("FAIL load_q cycle %0d: got %h expected %h", i, bus.q, nq);
      end
      mq = nq;
      dv = dv + 4'd5;
    end
  endtask

  task automatic test_reset_priority();
    logic [3:0] nq;
    // Step 0: rst with load/en; 1: load 9; 2: count up.
    for (int i = 0; i < 3; i++) begin
      rst      = (i == 0);
      bus.load = (i < 2);
      bus.d    = 4'd9;
      bus.en   = 1'b1;
      bus.up_down = 1'b1;
      #1;
      checks++;
      if (bus.tc !== 1'b0) begin
        errors++;
        $display("FAIL rstpri_tc step %0d: got %b expected 0", i, bus.tc);
      end
      if (i == 0)      exp_q.push_back(4'd0);
      else if (i == 1) exp_q.push_back(4'd9);
      else             exp_q.push_back(4'd10);
      @(posedge clk); #1;
      nq = exp_q.pop_front();
      checks++;
      if (bus.q !== nq) begin
        errors++;
        $display("FAIL rstpri_q step %0d: got %h expected %h", i, bus.q, nq);
      end
      mq = nq;
    end
    rst = 1'b0;
  endtask

  task automatic test_dir_flip();
    logic [3:0] nq;
    // Preload 7, then toggle direction each cycle, then hold.
    rst = 1'b0; bus.load = 1'b1; bus.d = 4'd7; bus.en = 1'b1; bus.up_down = 1'b0;
    exp_q.push_back(4'd7);
    @(posedge clk); #1;
    nq = exp_q.pop_front();
    checks++;
    if (bus.q !== nq) begin
      errors++;
      $display("FAIL flip_preload_q: got %h expected %h", bus.q, nq);
    end
    mq = nq;
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.en      = (i < 4);
      bus.up_down = ((i % 2) == 0);
      #1;
      checks++;
      if (bus.tc !== 1'b0) begin
        errors++;
        $display("FAIL flip_tc cycle %0d: got %b expected 0", i, bus.tc);
      end
      if (i >= 4)              nq = mq;
      else if ((i % 2) == 0)   nq = 4'd8;
      else                     nq = 4'd7;
      exp_q.push_back(nq);
      @(posedge clk); #1;
      nq = exp_q.pop_front();
      checks++;
      if (bus.q !== nq) begin
        errors++;
        $display("FAIL flip_q cycle %0d: got %h expected %h", i, bus.q, nq);
      end
      mq = nq;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mq     = 4'd0;
    rst    = 1'b0;
    bus.en = 1'b0; bus.up_down = 1'b0; bus.load = 1'b0; bus.d = 4'd0;
    @(posedge clk); #1;
    test_reset();
    test_down();
    test_up();
    test_load();
    test_reset_priority();
    test_dir_flip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
